// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 (7,5) convolutional encoder and hard-decision Viterbi decoder.
// The decoder keeps its survivors by register exchange and has a fixed latency of TB_DEPTH symbols.
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
);

  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_START = PM_W'(1) << (PM_W - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  // Code symbol {g0,g1} for input bit d leaving encoder state s.
  function automatic logic [1:0] code_sym(input logic d, input logic [1:0] s);
    return {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  function automatic logic [PM_W-1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] x;
    x = rx ^ ex;
    return PM_W'(x[1]) + PM_W'(x[0]);
  endfunction

  function automatic logic [PM_W-1:0] clear_msb(input logic [PM_W-1:0] pm);
    return {1'b0, pm[PM_W-2:0]};
  endfunction

  logic [1:0] enc_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_s_q     <= 2'b00;
      enc_d_o     <= 2'b00;
      enc_valid_o <= 1'b0;
    end else if (enc_enable_i) begin
      enc_d_o     <= code_sym(enc_d_i, enc_s_q);
      enc_valid_o <= 1'b1;
      enc_s_q     <= {enc_d_i, enc_s_q[1]};
    end else begin
      enc_valid_o <= 1'b0;
    end
  end

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     acs_pm [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] sv_q   [4];
  logic [TB_DEPTH-1:0] sv_d   [4];
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          st, p0, p1, best;
  logic [PM_W-1:0]     c0, c1;
  logic                all_msb;

  // Add-compare-select: state {a,b} is reached from {b,0} or {b,1} with input a.
  always_comb begin
    acs_pm  = '{default: '0};
    pm_d    = '{default: '0};
    sv_d    = '{default: '0};
    st      = 2'b00;
    p0      = 2'b00;
    p1      = 2'b00;
    c0      = '0;
    c1      = '0;
    best    = 2'b00;
    for (int s = 0; s < 4; s++) begin
      st = 2'(s);
      p0 = {st[0], 1'b0};
      p1 = {st[0], 1'b1};
      c0 = pm_q[p0] + branch_metric(dec_d_i, code_sym(st[1], p0));
      c1 = pm_q[p1] + branch_metric(dec_d_i, code_sym(st[1], p1));
      if (c1 < c0) begin
        acs_pm[st] = c1;
        sv_d[st]   = {sv_q[p1][TB_DEPTH-2:0], st[1]};
      end else begin
        acs_pm[st] = c0;
        sv_d[st]   = {sv_q[p0][TB_DEPTH-2:0], st[1]};
      end
    end
    all_msb = acs_pm[0][PM_W-1] & acs_pm[1][PM_W-1] & acs_pm[2][PM_W-1] & acs_pm[3][PM_W-1];
    for (int s = 0; s < 4; s++) begin
      st       = 2'(s);
      pm_d[st] = all_msb ? clear_msb(acs_pm[st]) : acs_pm[st];
    end
    // Strict less-than keeps the lowest index on ties.
    for (int s = 1; s < 4; s++) begin
      st = 2'(s);
      if (pm_d[st] < pm_d[best]) best = st;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q[0]     <= '0;
      pm_q[1]     <= PM_START;
      pm_q[2]     <= PM_START;
      pm_q[3]     <= PM_START;
      sv_q        <= '{default: '0};
      cnt_q       <= '0;
      dec_d_o     <= 1'b0;
      dec_valid_o <= 1'b0;
    end else if (dec_enable_i) begin
      pm_q        <= pm_d;
      sv_q        <= sv_d;
      dec_d_o     <= sv_d[best][TB_DEPTH-1];
      dec_valid_o <= (cnt_q == CNT_LAST);
      if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      dec_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vectors, loopback decode, error injection, zero stream
// and a mid-stream reset, all checked with immediate assertions.
module tb_viterbi_codec;
  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_valid_o;
  logic       dec_d_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] ms;
  logic       bits [0:1023];

  viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk(clk), .rst(rst),
    .enc_enable_i(enc_enable_i), .enc_d_i(enc_d_i),
    .enc_valid_o(enc_valid_o), .enc_d_o(enc_d_o),
    .dec_enable_i(dec_enable_i), .dec_d_i(dec_d_i),
    .dec_valid_o(dec_valid_o), .dec_d_o(dec_d_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_sym(input logic d, input logic [1:0] s);
    return {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enc_enable_i = 1'b0;
    dec_enable_i = 1'b0;
    #1;
    check("rst_enc_d", enc_d_o, 2'b00);
    check("rst_enc_v", enc_valid_o, 1'b0);
    check("rst_dec_d", dec_d_o, 1'b0);
    check("rst_dec_v", dec_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ms  = 2'b00;
  endtask

  task automatic enc_step(input logic en, input logic d, input logic [1:0] exp_d, input logic exp_v, input string tag);
    enc_enable_i = en;
    enc_d_i      = d;
    @(posedge clk);
    #1;
    check({tag, "_d"}, enc_d_o, exp_d);
    check({tag, "_v"}, enc_valid_o, exp_v);
  endtask

  // Drives the encoder and, in parallel, the decoder with a model-encoded (optionally corrupted) stream.
  task automatic stream(input int n, input int err_period, input int err_phase, input bit zeros, input bit gaps);
    logic       b;
    logic [1:0] sym;
    logic       held_d;
    logic [1:0] held_e;
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 7 == 3)) begin
        enc_enable_i = 1'b0;
        dec_enable_i = 1'b0;
        held_d = dec_d_o;
        held_e = enc_d_o;
        @(posedge clk);
        #1;
        check("gap_enc_v", enc_valid_o, 1'b0);
        check("gap_enc_d", enc_d_o, held_e);
        check("gap_dec_v", dec_valid_o, 1'b0);
        check("gap_dec_d", dec_d_o, held_d);
      end
      b = zeros ? 1'b0 : 1'($urandom_range(0, 1));
      bits[k] = b;
      sym = ref_sym(b, ms);
      ms  = {b, ms[1]};
      enc_enable_i = 1'b1;
      enc_d_i      = b;
      dec_enable_i = 1'b1;
      dec_d_i = sym ^ (((err_period > 0) && (k % err_period == err_phase)) ? 2'b11 : 2'b00);
      @(posedge clk);
      #1;
      check("str_enc_d", enc_d_o, sym);
      check("str_enc_v", enc_valid_o, 1'b1);
      if (k >= TB_DEPTH - 1) begin
        check("str_dec_v", dec_valid_o, 1'b1);
        check("str_dec_d", dec_d_o, bits[k-TB_DEPTH+1]);
      end else begin
        check("str_dec_v_early", dec_valid_o, 1'b0);
      end
    end
    enc_enable_i = 1'b0;
    dec_enable_i = 1'b0;
  endtask

  initial begin
    ms = 2'b00;
    // Encoder impulse response.
    do_reset();
    enc_step(1'b1, 1'b1, 2'b11, 1'b1, "imp0");
    enc_step(1'b1, 1'b0, 2'b10, 1'b1, "imp1");
    enc_step(1'b1, 1'b0, 2'b11, 1'b1, "imp2");
    enc_step(1'b1, 1'b0, 2'b00, 1'b1, "imp3");
    enc_step(1'b0, 1'b0, 2'b00, 1'b0, "imp_idle");

    // Encoder enable gap: 1, gap, 1.
    do_reset();
    enc_step(1'b1, 1'b1, 2'b11, 1'b1, "gap0");
    enc_step(1'b0, 1'b0, 2'b11, 1'b0, "gap_hold");
    enc_step(1'b1, 1'b1, 2'b01, 1'b1, "gap1");

    // Clean loopback, then with enable gaps.
    do_reset();
    stream(256, 0, 0, 1'b0, 1'b0);
    do_reset();
    stream(128, 0, 0, 1'b0, 1'b1);

    // One fully inverted symbol in every 16.
    do_reset();
    stream(256, 16, 5, 1'b0, 1'b0);
    do_reset();
    stream(256, 16, 11, 1'b0, 1'b1);

    // Long all-zero stream exercises the counter saturation and metric bounds.
    do_reset();
    stream(1000, 0, 0, 1'b1, 1'b0);

    // Reset asserted mid-stream at symbol 40, then a fresh stream.
    do_reset();
    stream(40, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_dec_v", dec_valid_o, 1'b0);
    check("mid_rst_dec_d", dec_d_o, 1'b0);
    check("mid_rst_enc_v", enc_valid_o, 1'b0);
    check("mid_rst_enc_d", enc_d_o, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    ms  = 2'b00;
    stream(64, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
